// File: rtl/cache_fill_fsm_pkg.sv
// cache_fill_fsm_pkg: shared state encoding and block geometry for the cache fill FSM
package cache_fill_fsm_pkg;
  localparam int WORD_IDX_W = 3;
  localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;
  typedef enum logic {FILL_IDLE = 1'b0, FILL_BUSY = 1'b1} fill_state_e;
endpackage

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: miss, memory and cache-array signals of one fill FSM instance
// CRITICAL_WORD_FIRST_EN adds crit_word_ready
interface cache_fill_fsm_if #(parameter int ADDR_W = 16);
  logic miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic memory_data_valid;
  logic [15:0] memory_data;
  logic fsm_busy;
  logic memory_en;
  logic [ADDR_W-1:0] memory_address;
  logic write_data_array;
  logic write_tag_array;
  logic [ADDR_W-1:0] fill_addr;
  logic [15:0] fill_data;
`ifdef CRITICAL_WORD_FIRST_EN
  logic crit_word_ready;
  modport master(
    input miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_en, memory_address, write_data_array, write_tag_array,
    output fill_addr, fill_data, crit_word_ready
  );
  modport slave(
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input fsm_busy, memory_en, memory_address, write_data_array, write_tag_array,
    input fill_addr, fill_data, crit_word_ready
  );
`else
  modport master(
    input miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_en, memory_address, write_data_array, write_tag_array,
    output fill_addr, fill_data
  );
  modport slave(
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input fsm_busy, memory_en, memory_address, write_data_array, write_tag_array,
    input fill_addr, fill_data
  );
`endif
endinterface

// File: rtl/cache_fill_fsm_fill_word_counter.sv
// fill_word_counter: word counter for one side of a block fill, done once N words are counted
module fill_word_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [WORD_IDX_W-1:0] idx,
  output logic                  done
);
  logic [WORD_IDX_W:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign idx = cnt_q[WORD_IDX_W-1:0];
  assign done = cnt_q == (WORD_IDX_W + 1)'(N);
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: L1 miss handler fetching one 8-word block from main memory
// CRITICAL_WORD_FIRST_EN starts the fill at the missed word and adds crit_word_ready
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W = 16
) (
  input logic clk,
  input logic rst_n,
  cache_fill_fsm_if.master bus
);
  fill_state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WORD_IDX_W-1:0] widx_q, widx_d, start, issue_idx, recv_idx;
  logic [15:0] data_q, data_d;
  logic vld_q, vld_d;
  logic busy, accept, issue_inc, recv_inc, issue_done, recv_done, last_wr;

  function automatic logic [ADDR_W-1:0] word_addr(logic [ADDR_W-1:0] base, logic [WORD_IDX_W-1:0] idx);
    return base | ADDR_W'({idx, 1'b0});
  endfunction

  assign busy = state_q == FILL_BUSY;
  assign accept = !busy && bus.miss_detected;
  assign issue_inc = busy && !issue_done;
  // valids past the eighth are a protocol error and dropped
  assign recv_inc = busy && bus.memory_data_valid && !recv_done;
  assign last_wr = vld_q && widx_q == '1;

  fill_word_counter #(.N(BLOCK_WORDS)) u_issue (
    .clk(clk), .rst_n(rst_n), .clr(!busy), .inc(issue_inc), .idx(issue_idx), .done(issue_done)
  );
  fill_word_counter #(.N(BLOCK_WORDS)) u_recv (
    .clk(clk), .rst_n(rst_n), .clr(!busy), .inc(recv_inc), .idx(recv_idx), .done(recv_done)
  );

`ifdef CRITICAL_WORD_FIRST_EN
  logic [WORD_IDX_W-1:0] start_q, start_d;
  always_comb start_d = accept ? bus.miss_address[WORD_IDX_W:1] : start_q;
  always_ff @(posedge clk) begin
    if (!rst_n) start_q <= '0;
    else start_q <= start_d;
  end
  assign start = start_q;
  assign bus.crit_word_ready = vld_q && widx_q == '0;
`else
  assign start = '0;
`endif

  always_comb begin
    state_d = accept ? FILL_BUSY : last_wr ? FILL_IDLE : state_q;
    base_d = accept ? bus.miss_address & BLOCK_OFFSET_MASK : base_q;
    vld_d = recv_inc;
    data_d = recv_inc ? bus.memory_data : data_q;
    widx_d = recv_inc ? recv_idx : widx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL_IDLE;
      base_q <= '0;
      vld_q <= 1'b0;
      data_q <= '0;
      widx_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      vld_q <= vld_d;
      data_q <= data_d;
      widx_q <= widx_d;
    end
  end

  // offset bits are or-ed into an aligned base, so addresses never leave the block
  always_comb begin
    bus.fsm_busy = busy;
    bus.memory_en = issue_inc;
    bus.memory_address = issue_inc ? word_addr(base_q, issue_idx + start) : '0;
    bus.write_data_array = vld_q;
    bus.write_tag_array = last_wr;
    bus.fill_addr = vld_q ? word_addr(base_q, widx_q + start) : '0;
    bus.fill_data = data_q;
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized bench for cache_fill_fsm against a block-fill reference model
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cache_fill_fsm_if bus();

  cache_fill_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // reference model: a fill is eight words of an aligned block in rotated order
  bit m_busy = 0;
  bit pend = 0;
  logic [15:0] m_base = 0;
  logic [15:0] pend_data = 0;
  int m_start = 0;
  int issued = 0;
  int caps = 0;
  int pend_idx = 0;
  int tags = 0;

  // memory model: fixed read latency, returns a salted function of the address
  int lat = 4;
  int cyc = 0;
  logic [15:0] salt = 16'h5a3c;
  int due_q[$];
  logic [15:0] dat_q[$];

  function automatic logic [15:0] word_addr(input int k);
    return m_base + 16'(2 * ((k + m_start) % 8));
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd7) ^ salt;
  endfunction

  task automatic step(input bit miss, input logic [15:0] addr, input bit rst, input bit spur);
    bit mv, nxt_pend, done, en;
    logic [15:0] md;
    @(negedge clk);
    en = m_busy && issued < 8;
    check("fsm_busy", bus.fsm_busy, m_busy);
    check("memory_en", bus.memory_en, en);
    check("memory_address", bus.memory_address, en ? word_addr(issued) : 16'h0);
    check("write_data_array", bus.write_data_array, pend);
    check("write_tag_array", bus.write_tag_array, pend && pend_idx == 7);
    check("fill_addr", bus.fill_addr, pend ? word_addr(pend_idx) : 16'h0);
    check("fill_data", bus.fill_data, pend_data);
`ifdef CRITICAL_WORD_FIRST_EN
    check("crit_word_ready", bus.crit_word_ready, pend && pend_idx == 0);
`endif
    if (bus.write_tag_array) tags++;
    if (bus.memory_en) begin
      due_q.push_back(cyc + lat);
      dat_q.push_back(mem_word(bus.memory_address));
    end
    mv = 0;
    md = 16'($urandom);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      mv = 1;
      md = dat_q.pop_front();
      void'(due_q.pop_front());
    end else if (spur && $urandom_range(0, 2) == 0) mv = 1;
    bus.miss_detected = miss;
    bus.miss_address = addr;
    bus.memory_data_valid = mv;
    bus.memory_data = md;
    rst_n = !rst;
    if (rst) begin
      due_q.delete();
      dat_q.delete();
      m_busy = 0; pend = 0; m_base = 0; pend_data = 0;
      m_start = 0; issued = 0; caps = 0; pend_idx = 0;
    end else begin
      nxt_pend = m_busy && mv && caps < 8;
      done = m_busy && pend && pend_idx == 7;
      if (en) issued++;
      if (nxt_pend) begin
        pend_idx = caps;
        pend_data = md;
        caps++;
      end
      pend = nxt_pend;
      if (!m_busy && miss) begin
        m_busy = 1;
        m_base = addr & 16'hFFF0;
`ifdef CRITICAL_WORD_FIRST_EN
        m_start = int'(addr[3:1]);
`else
        m_start = 0;
`endif
        issued = 0;
        caps = 0;
      end else if (done) m_busy = 0;
    end
    cyc++;
  endtask

  task automatic run_fill(input logic [15:0] addr, input bit hold, input bit spur);
    step(1, addr, 0, 0);
    for (int i = 0; i < 80 && m_busy; i++) step(hold, 16'($urandom), 0, spur);
    check("fill_timeout", m_busy, 0);
  endtask

  task automatic idle(input int n, input bit spur);
    for (int i = 0; i < n; i++) step(0, 16'($urandom), 0, spur);
  endtask

  int t0;

  initial begin
    bus.miss_detected = 0;
    bus.miss_address = 0;
    bus.memory_data_valid = 0;
    bus.memory_data = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    idle(8, 1);
    t0 = tags;
    run_fill(16'h1236, 0, 0);
    check("tag_once_1236", tags - t0, 1);
    idle(2, 0);
    run_fill(16'h2000, 1, 0);
    run_fill(16'h3002, 1, 0);
    idle(10, 0);
    step(1, 16'h5554, 0, 0);
    for (int i = 0; i < 40 && !(pend && pend_idx == 2); i++) step(0, 0, 0, 0);
    check("third_write_reached", pend && pend_idx == 2, 1);
    t0 = tags;
    step(0, 0, 1, 0);
    idle(3, 0);
    check("no_tag_after_reset", tags - t0, 0);
    run_fill(16'h0040, 0, 0);
    idle(8, 0);
    run_fill(16'hFFFE, 0, 0);
    idle(8, 0);
    run_fill(16'h100A, 0, 0);
    idle(8, 0);
    for (int f = 0; f < 30; f++) begin
      lat = $urandom_range(1, 6);
      salt = 16'($urandom);
      run_fill(16'($urandom), 1'($urandom_range(0, 1)), f % 5 == 4);
      if (f % 7 == 6) begin
        step(1, 16'($urandom), 0, 0);
        for (int i = 0; i < $urandom_range(0, 10); i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
      end
      idle(12, $urandom_range(0, 1) == 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
